// File: rtl/low_freq_gen.sv
// low_freq_gen: square-wave generator for a 4-digit BCD frequency (1..9999 Hz).
// Flow: BCD -> binary (4 cycles), 1e6 / f restoring divide (20 cycles), then a
// period generator stepped by a 1 us tick derived from i_clk.
// Optional: define LFG_CYCLE_COUNT_EN to add o_cycles, a saturating count of
// completed full periods.
module low_freq_gen #(
    parameter int CLK_PER_US = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_freq_bcd,
    output logic        o_signal,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
`ifdef LFG_CYCLE_COUNT_EN
    output logic [19:0] o_period_us,
    output logic [15:0] o_cycles
`else
    output logic [19:0] o_period_us
`endif
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    typedef enum logic [1:0] {e_idle, e_convert, e_divide, e_run} state_t;

    state_t          r_state, w_next;
    logic [15:0]     r_bcd;
    logic [13:0]     r_acc;
    logic [4:0]      r_step;
    logic [19:0]     r_quo;
    logic [13:0]     r_rem;
    logic [PW-1:0]   r_pre;
    logic [19:0]     r_ph;
    logic [19:0]     r_period;
    logic            r_signal, r_done, r_err, r_ready;

    logic [3:0]      w_digit;
    logic            w_digit_bad;
    logic [13:0]     w_acc_next;
    logic [14:0]     w_rem_sh;
    logic            w_ge;
    logic [13:0]     w_rem_diff;
    logic [13:0]     w_rem_next;
    logic [19:0]     w_quo_next;
    logic [19:0]     w_high, w_low, w_phase_len;
    logic            w_tick, w_phase_end;
    logic            w_accept, w_err_set, w_conv_done, w_div_done;

    // Digits are consumed from the top nibble, thousands first.
    assign w_digit     = r_bcd[15:12];
    assign w_digit_bad = (w_digit > 4'd9);
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + {10'd0, w_digit};

    // Restoring divide step; the remainder stays below the 14-bit divisor, so
    // the low 14 bits of the difference are exact.
    assign w_rem_sh   = {r_rem, r_quo[19]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_acc});
    assign w_rem_diff = w_rem_sh[13:0] - r_acc;
    assign w_rem_next = w_ge ? w_rem_diff : w_rem_sh[13:0];
    assign w_quo_next = {r_quo[18:0], w_ge};

    // High gets the floor half, low takes the odd microsecond.
    assign w_high      = r_period >> 1;
    assign w_low       = r_period - w_high;
    assign w_phase_len = r_signal ? w_high : w_low;
    assign w_tick      = (r_pre == PW'(CLK_PER_US - 1));
    assign w_phase_end = w_tick && (r_ph == w_phase_len - 20'd1);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= e_idle;
        else       r_state <= w_next;
    end

    // Next state and control strobes; i_stop beats i_start everywhere.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        w_conv_done = 1'b0;
        w_div_done  = 1'b0;
        case (r_state)
            e_idle: begin
                if (i_start && !i_stop) begin
                    w_accept = 1'b1;
                    w_next   = e_convert;
                end
            end
            e_convert: begin
                if (i_stop) begin
                    w_next = e_idle;
                end else if (w_digit_bad) begin
                    w_err_set = 1'b1;
                    w_next    = e_idle;
                end else if (r_step == 5'd3) begin
                    if (w_acc_next == 14'd0) begin
                        w_err_set = 1'b1;
                        w_next    = e_idle;
                    end else begin
                        w_conv_done = 1'b1;
                        w_next      = e_divide;
                    end
                end
            end
            e_divide: begin
                if (i_stop) begin
                    w_next = e_idle;
                end else if (r_step == 5'd19) begin
                    w_div_done = 1'b1;
                    w_next     = e_run;
                end
            end
            e_run: begin
                if (i_stop) begin
                    w_next = e_idle;
                end else if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = e_convert;
                end
            end
            default: w_next = e_idle;
        endcase
    end

    // Datapath: conversion, division, and the tick/phase generator.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bcd    <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_pre    <= '0;
            r_ph     <= '0;
            r_period <= '0;
            r_signal <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_done  <= w_div_done;
            r_ready <= (w_next == e_idle);
            if (w_err_set) r_err <= 1'b1;
            if (w_accept) begin
                r_bcd    <= i_freq_bcd;
                r_acc    <= '0;
                r_step   <= '0;
                r_err    <= 1'b0;
                r_signal <= 1'b0;
            end else begin
                case (r_state)
                    e_convert: begin
                        r_bcd  <= {r_bcd[11:0], 4'd0};
                        r_acc  <= w_acc_next;
                        r_step <= w_conv_done ? 5'd0 : r_step + 5'd1;
                        if (w_conv_done) begin
                            r_quo <= 20'd1000000;
                            r_rem <= '0;
                        end
                    end
                    e_divide: begin
                        r_quo  <= w_quo_next;
                        r_rem  <= w_rem_next;
                        r_step <= r_step + 5'd1;
                        if (w_div_done) begin
                            r_period <= w_quo_next;
                            r_signal <= 1'b1;
                            r_pre    <= '0;
                            r_ph     <= '0;
                        end
                    end
                    e_run: begin
                        if (i_stop) begin
                            r_signal <= 1'b0;
                        end else begin
                            r_pre <= w_tick ? '0 : r_pre + PW'(1);
                            if (w_tick) begin
                                if (w_phase_end) begin
                                    r_ph     <= '0;
                                    r_signal <= ~r_signal;
                                end else begin
                                    r_ph <= r_ph + 20'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LFG_CYCLE_COUNT_EN
    logic [15:0] r_cycles;
    logic        w_rise;

    // The e_run entry edge is the first rise; only later rises close a period.
    assign w_rise = (r_state == e_run) && !i_stop && !i_start && w_phase_end && !r_signal;

    // Saturating completed-period counter, cleared when a new request starts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                r_cycles <= '0;
        else if (w_accept)                        r_cycles <= '0;
        else if (w_rise && r_cycles != 16'hFFFF)  r_cycles <= r_cycles + 16'd1;
    end

    assign o_cycles = r_cycles;
`endif

    assign o_signal    = r_signal;
    assign o_ready     = r_ready;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_period_us = r_period;

endmodule

// File: tb/tb_low_freq_gen.sv
// tb_low_freq_gen: randomized and directed checks of low_freq_gen at
// CLK_PER_US=4 against an arithmetic model (f from digits, period = 1e6/f).
module tb_low_freq_gen;

    localparam int CPU = 4;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_stop;
    logic [15:0] i_freq_bcd;
    logic        o_signal, o_ready, o_done, o_err;
    logic [19:0] o_period_us;
`ifdef LFG_CYCLE_COUNT_EN
    logic [15:0] o_cycles;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    low_freq_gen #(.CLK_PER_US(CPU)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_freq_bcd  (i_freq_bcd),
        .o_signal    (o_signal),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_err       (o_err),
`ifdef LFG_CYCLE_COUNT_EN
        .o_period_us (o_period_us),
        .o_cycles    (o_cycles)
`else
        .o_period_us (o_period_us)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bcd_val(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int f);
        logic [15:0] b;
        b[15:12] = 4'(f / 1000);
        b[11:8]  = 4'((f / 100) % 10);
        b[7:4]   = 4'((f / 10) % 10);
        b[3:0]   = 4'(f % 10);
        return b;
    endfunction

    // Pulse i_start, then watch cycles N+1.. for done / err / first high.
    task automatic do_start(input logic [15:0] bcd, output int done_k, output int err_k, output int hi_k);
        done_k = 0; err_k = 0; hi_k = 0;
        @(negedge clk); i_start = 1'b1; i_freq_bcd = bcd;
        @(negedge clk); i_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (o_err && err_k == 0) err_k = k;
            if (o_signal && hi_k == 0) hi_k = k;
            if (o_done) begin done_k = k; break; end
        end
    endtask

    // Count clocks the output holds at lvl, starting with the current one.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (o_signal === lvl && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_valid(input logic [15:0] bcd, input int nphase);
        int f, p, h, l, dk, ek, hk, n;
        f = bcd_val(bcd);
        p = 1000000 / f;
        h = p / 2;
        l = p - h;
        do_start(bcd, dk, ek, hk);
        chk("done_latency", dk, 25);
        chk("first_high_cycle", hk, 25);
        chk("err_cleared", ek, 0);
        chk("period", o_period_us, p);
        for (int i = 0; i < nphase; i++) begin
            measure(i % 2 == 0, n);
            chk((i % 2 == 0) ? "high_len" : "low_len", n, ((i % 2 == 0) ? h : l) * CPU);
        end
    endtask

    task automatic do_stop();
        @(negedge clk); i_stop = 1'b1;
        @(negedge clk); i_stop = 1'b0;
        chk("stop_signal", o_signal, 0);
        chk("stop_ready", o_ready, 1);
    endtask

    initial begin
        int dk, ek, hk, rises;
        logic prev;
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_freq_bcd = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_signal", o_signal, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_period", o_period_us, 0);
        i_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", o_ready, 1);

        // 1000 Hz: 2000 clocks high, 2000 low, repeating.
        run_valid(16'h1000, 3);

        // Random frequencies, each restarting from e_run.
        repeat (5) run_valid(to_bcd(int'($urandom_range(2000, 9999))), 2);
        do_stop();

        // 3 Hz: period 333333, first high phase far exceeds the window.
        run_valid(16'h0003, 0);
        repeat (200) @(negedge clk);
        chk("f3_still_high", o_signal, 1);
        do_stop();
        chk("f3_period_kept", o_period_us, 333333);

        // Zero frequency: error at N+5, no done, output stays low.
        do_start(16'h0000, dk, ek, hk);
        chk("zero_err_cycle", ek, 5);
        chk("zero_no_done", dk, 0);
        chk("zero_no_high", hk, 0);
        chk("zero_ready", o_ready, 1);
        chk("zero_period_kept", o_period_us, 333333);

        // Valid start after an error clears it; count rising edges.
        run_valid(16'h9999, 0);
        rises = 1; prev = o_signal;
        for (int i = 0; i < 3000 && rises < 4; i++) begin
            @(negedge clk);
            if (o_signal && !prev) rises++;
            prev = o_signal;
        end
        chk("rises_seen", rises, 4);
`ifdef LFG_CYCLE_COUNT_EN
        chk("cycles", o_cycles, 3);
`endif

        // Restart in e_run at 50 Hz: low through N+24, high at N+25.
        run_valid(16'h0050, 0);
        do_stop();

        // Bad digit in position 2: error two cycles in, period untouched.
        do_start(16'h1A00, dk, ek, hk);
        chk("bad_err_cycle", ek, 3);
        chk("bad_no_done", dk, 0);
        chk("bad_period_kept", o_period_us, 20000);
        chk("bad_ready", o_ready, 1);

        // Reset in the middle of the divide.
        @(negedge clk); i_start = 1'b1; i_freq_bcd = 16'h1234;
        @(negedge clk); i_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_signal", o_signal, 0);
        chk("midrst_ready", o_ready, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_err", o_err, 0);
        chk("midrst_period", o_period_us, 0);
        @(negedge clk); i_rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", o_ready, 1);
        dk = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_done) dk = 1;
        end
        chk("midrst_no_done", dk, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
